// File: rtl/sumador_serie_param_if.sv
// Operand/result handshake bundle for sumador_serie_param.
// Optional subtraction signals exist only when SUMADOR_SERIE_RESTA_EN is defined.
interface sumador_serie_param_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] i_operando_a;
   logic [WIDTH-1:0] i_operando_b;
   logic             i_acarreo;
   logic             i_valido;
   logic             o_listo;
   logic [WIDTH-1:0] o_suma;
   logic             o_acarreo;
   logic             o_valido;
   logic             i_listo;
`ifdef SUMADOR_SERIE_RESTA_EN
   logic             i_resta;
   logic             o_desborde;
`endif

   // master: the surrounding pipeline (upstream source plus downstream sink)
   modport master (
      output i_operando_a, i_operando_b, i_acarreo, i_valido, i_listo,
`ifdef SUMADOR_SERIE_RESTA_EN
      output i_resta,
      input  o_desborde,
`endif
      input  o_listo, o_suma, o_acarreo, o_valido
   );

   modport slave (
      input  i_operando_a, i_operando_b, i_acarreo, i_valido, i_listo,
`ifdef SUMADOR_SERIE_RESTA_EN
      input  i_resta,
      output o_desborde,
`endif
      output o_listo, o_suma, o_acarreo, o_valido
   );
endinterface

// File: rtl/sumador_serie_param.sv
// Digit-serial WIDTH-bit adder, DIGIT_W bits per clock, LSB digit first, valid/ready on both sides.
// Define SUMADOR_SERIE_RESTA_EN to add subtraction (i_resta) and signed overflow (o_desborde).
//
// state     | meaning
// IDLE      | o_listo=1, waiting for an operation
// SUMA      | adding one digit per cycle through the registered carry
// RESULTADO | o_valido=1, result held until i_listo
module sumador_serie_param #(
   parameter int WIDTH   = 16,
   parameter int DIGIT_W = 4
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   sumador_serie_param_if.slave bus
);
   localparam int NUM_DIG = WIDTH / DIGIT_W;
   localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

   generate
      if ((DIGIT_W < 1) || (DIGIT_W > WIDTH) || (WIDTH % DIGIT_W != 0)) begin : g_param_err
         $error("sumador_serie_param: WIDTH must be a multiple of DIGIT_W, 1 <= DIGIT_W <= WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SUMA, RESULTADO} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] op_a, op_b, acc, acc_next;
   logic             carry_reg;
   logic [IDX_W-1:0] k;
   logic [DIGIT_W:0] dig_sum;
   logic             last_dig;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

`ifdef SUMADOR_SERIE_RESTA_EN
   logic a_msb, b_msb;
   assign b_eff   = bus.i_resta ? ~bus.i_operando_b : bus.i_operando_b;
   assign cin_eff = bus.i_resta ? ~bus.i_acarreo    : bus.i_acarreo;
`else
   assign b_eff   = bus.i_operando_b;
   assign cin_eff = bus.i_acarreo;
`endif

   // Operands shift right so the current digit is always the bottom DIGIT_W bits
   assign dig_sum  = {1'b0, op_a[DIGIT_W-1:0]} + {1'b0, op_b[DIGIT_W-1:0]}
                   + {{DIGIT_W{1'b0}}, carry_reg};
   assign last_dig = (k == IDX_W'(NUM_DIG - 1));
   assign acc_next = (acc >> DIGIT_W) | (WIDTH'(dig_sum[DIGIT_W-1:0]) << (WIDTH - DIGIT_W));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (bus.i_valido) state_next = SUMA;
         SUMA:      if (last_dig)     state_next = RESULTADO;
         RESULTADO: if (bus.i_listo)  state_next = IDLE;
         default:                     state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.o_listo  = (state == IDLE);
      bus.o_valido = (state == RESULTADO);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_a          <= '0;
         op_b          <= '0;
         acc           <= '0;
         carry_reg     <= 1'b0;
         k             <= '0;
         bus.o_suma    <= '0;
         bus.o_acarreo <= 1'b0;
`ifdef SUMADOR_SERIE_RESTA_EN
         a_msb          <= 1'b0;
         b_msb          <= 1'b0;
         bus.o_desborde <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_valido) begin
                  op_a      <= bus.i_operando_a;
                  op_b      <= b_eff;
                  carry_reg <= cin_eff;
                  k         <= '0;
`ifdef SUMADOR_SERIE_RESTA_EN
                  a_msb     <= bus.i_operando_a[WIDTH-1];
                  b_msb     <= b_eff[WIDTH-1];
`endif
               end
            end
            SUMA: begin
               op_a      <= op_a >> DIGIT_W;
               op_b      <= op_b >> DIGIT_W;
               carry_reg <= dig_sum[DIGIT_W];
               acc       <= acc_next;
               k         <= k + 1'b1;
               if (last_dig) begin
                  bus.o_suma    <= acc_next;
                  bus.o_acarreo <= dig_sum[DIGIT_W];
`ifdef SUMADOR_SERIE_RESTA_EN
                  // Overflow: like-signed operands giving a result of the other sign
                  bus.o_desborde <= (a_msb == b_msb) && (dig_sum[DIGIT_W-1] != a_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sumador_serie_param.sv
// Directed bench for sumador_serie_param: 16/4 instance plus 8-bit instances with DIGIT_W 8, 2, 1.
// Subtraction vectors are exercised when SUMADOR_SERIE_RESTA_EN is defined.
module tb_sumador_serie_param;
   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 i_clk = ~i_clk;

   sumador_serie_param_if #(.WIDTH(16)) if16 ();
   sumador_serie_param_if #(.WIDTH(8))  if8a ();
   sumador_serie_param_if #(.WIDTH(8))  if8b ();
   sumador_serie_param_if #(.WIDTH(8))  if8c ();

   sumador_serie_param #(.WIDTH(16), .DIGIT_W(4)) dut16 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if16.slave));
   sumador_serie_param #(.WIDTH(8),  .DIGIT_W(8)) dut8a (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if8a.slave));
   sumador_serie_param #(.WIDTH(8),  .DIGIT_W(2)) dut8b (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if8b.slave));
   sumador_serie_param #(.WIDTH(8),  .DIGIT_W(1)) dut8c (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if8c.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic resta);
      int n = 0;
      while (!if16.o_listo && n < 50) begin tick(); n++; end
      chk("start16_listo", 32'(if16.o_listo), 32'd1);
      if16.i_operando_a = a;
      if16.i_operando_b = b;
      if16.i_acarreo    = cin;
`ifdef SUMADOR_SERIE_RESTA_EN
      if16.i_resta      = resta;
`else
      if (resta) $display("note: subtraction requested without SUMADOR_SERIE_RESTA_EN");
`endif
      if16.i_valido     = 1'b1;
      tick();
      if16.i_valido     = 1'b0;
   endtask

   // Returns cycles from the handshake edge to o_valido, or -1 on timeout
   task automatic wait16(output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (if16.o_valido) begin lat = c; break; end
      end
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      logic [8:0] ref_sum;
      int la = -1, lb = -1, lc = -1;
      logic [8:0] ra = '0, rb = '0, rc = '0;
      ref_sum = 9'(a) + 9'(b) + 9'(cin);
      if8a.i_operando_a = a; if8b.i_operando_a = a; if8c.i_operando_a = a;
      if8a.i_operando_b = b; if8b.i_operando_b = b; if8c.i_operando_b = b;
      if8a.i_acarreo = cin;  if8b.i_acarreo = cin;  if8c.i_acarreo = cin;
      chk("run8_listo", 32'({if8a.o_listo, if8b.o_listo, if8c.o_listo}), 32'h7);
      if8a.i_valido = 1'b1; if8b.i_valido = 1'b1; if8c.i_valido = 1'b1;
      tick();
      if8a.i_valido = 1'b0; if8b.i_valido = 1'b0; if8c.i_valido = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (la < 0 && if8a.o_valido) begin la = c; ra = {if8a.o_acarreo, if8a.o_suma}; end
         if (lb < 0 && if8b.o_valido) begin lb = c; rb = {if8b.o_acarreo, if8b.o_suma}; end
         if (lc < 0 && if8c.o_valido) begin lc = c; rc = {if8c.o_acarreo, if8c.o_suma}; end
      end
      chk("lat_d8", 32'(la), 32'd1);
      chk("lat_d2", 32'(lb), 32'd4);
      chk("lat_d1", 32'(lc), 32'd8);
      chk("sum_d8", 32'(ra), 32'(ref_sum));
      chk("sum_d2", 32'(rb), 32'(ref_sum));
      chk("sum_d1", 32'(rc), 32'(ref_sum));
   endtask

   initial begin
      int lat;
      logic [15:0] held;
      logic        never;

      if16.i_operando_a = '0; if16.i_operando_b = '0; if16.i_acarreo = 1'b0;
      if16.i_valido = 1'b0;   if16.i_listo = 1'b1;
      if8a.i_operando_a = '0; if8a.i_operando_b = '0; if8a.i_acarreo = 1'b0; if8a.i_valido = 1'b0; if8a.i_listo = 1'b1;
      if8b.i_operando_a = '0; if8b.i_operando_b = '0; if8b.i_acarreo = 1'b0; if8b.i_valido = 1'b0; if8b.i_listo = 1'b1;
      if8c.i_operando_a = '0; if8c.i_operando_b = '0; if8c.i_acarreo = 1'b0; if8c.i_valido = 1'b0; if8c.i_listo = 1'b1;
`ifdef SUMADOR_SERIE_RESTA_EN
      if16.i_resta = 1'b0; if8a.i_resta = 1'b0; if8b.i_resta = 1'b0; if8c.i_resta = 1'b0;
`endif

      // Reset values
      #23;
      chk("rst_listo",   32'(if16.o_listo),   32'd1);
      chk("rst_valido",  32'(if16.o_valido),  32'd0);
      chk("rst_suma",    32'(if16.o_suma),    32'h0000);
      chk("rst_acarreo", 32'(if16.o_acarreo), 32'd0);
`ifdef SUMADOR_SERIE_RESTA_EN
      chk("rst_desborde", 32'(if16.o_desborde), 32'd0);
`endif
      tick();
      i_rst_n = 1'b1;
      tick();

      // Basic sums
      start16(16'h1234, 16'h4321, 1'b1, 1'b0);
      wait16(lat);
      chk("lat_1234", 32'(lat), 32'd4);
      chk("sum_1234", 32'(if16.o_suma), 32'h5556);
      chk("cy_1234",  32'(if16.o_acarreo), 32'd0);
      tick();
      chk("idle_after_1234", 32'(if16.o_listo), 32'd1);
      chk("hold_in_idle",    32'(if16.o_suma), 32'h5556);

      start16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait16(lat);
      chk("lat_ffff", 32'(lat), 32'd4);
      chk("sum_ffff", 32'(if16.o_suma), 32'h0000);
      chk("cy_ffff",  32'(if16.o_acarreo), 32'd1);
      tick();

      // Backpressure with an ignored request during the stall
      if16.i_listo = 1'b0;
      start16(16'hABCD, 16'h1111, 1'b0, 1'b0);
      wait16(lat);
      chk("bp_sum", 32'(if16.o_suma), 32'hBCDE);
      held = if16.o_suma;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin
            if16.i_operando_a = 16'h0001; if16.i_operando_b = 16'h0001; if16.i_valido = 1'b1;
         end
         if (c == 2) if16.i_valido = 1'b0;
         tick();
         chk("bp_stable_suma", 32'(if16.o_suma), 32'(held));
         chk("bp_stable_cy",   32'(if16.o_acarreo), 32'd0);
         chk("bp_listo",       32'(if16.o_listo), 32'd0);
         chk("bp_valido",      32'(if16.o_valido), 32'd1);
      end
      if16.i_listo = 1'b1;
      tick();
      chk("bp_release_listo",  32'(if16.o_listo), 32'd1);
      chk("bp_release_valido", 32'(if16.o_valido), 32'd0);
      tick();
      chk("bp_not_queued", 32'(if16.o_listo), 32'd1);
      chk("bp_keep_sum",   32'(if16.o_suma), 32'hBCDE);

      // Reset mid-operation
      start16(16'h00FF, 16'h0001, 1'b0, 1'b0);
      tick();
      i_rst_n = 1'b0;
      #3;
      chk("midrst_suma",   32'(if16.o_suma), 32'h0000);
      chk("midrst_listo",  32'(if16.o_listo), 32'd1);
      tick();
      i_rst_n = 1'b1;
      never = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (if16.o_valido) never = 1'b0;
      end
      chk("midrst_no_valido", 32'(never), 32'd1);
      start16(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait16(lat);
      chk("midrst_next_lat", 32'(lat), 32'd4);
      chk("midrst_next_sum", 32'(if16.o_suma), 32'h0002);
      tick();

      // Width/digit sweep
      run8(8'hFF, 8'hFF, 1'b1);
      run8(8'h5A, 8'hA5, 1'b0);
      run8(8'h80, 8'h80, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

`ifdef SUMADOR_SERIE_RESTA_EN
      start16(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait16(lat);
      chk("sub_5_7",     32'(if16.o_suma), 32'hFFFE);
      chk("sub_5_7_cy",  32'(if16.o_acarreo), 32'd0);
      chk("sub_5_7_ovf", 32'(if16.o_desborde), 32'd0);
      tick();
      start16(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait16(lat);
      chk("sub_8000_1",     32'(if16.o_suma), 32'h7FFF);
      chk("sub_8000_1_ovf", 32'(if16.o_desborde), 32'd1);
      chk("sub_8000_1_cy",  32'(if16.o_acarreo), 32'd1);
      tick();
      start16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      wait16(lat);
      chk("add_7fff_1",     32'(if16.o_suma), 32'h8000);
      chk("add_7fff_1_ovf", 32'(if16.o_desborde), 32'd1);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
